// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the interval timer bank: the per-channel FSM state
// encoding, the default counter width, and a helper that validates a PERIOD
// parameter against the counter width at elaboration time.
// -----------------------------------------------------------------------------
package timer_pkg;

  // Per-channel Moore FSM states; the encoding is fixed and visible to firmware
  // debug, so the values are pinned explicitly.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIRE = 2'b10,
    ST_DONE = 2'b11
  } timer_state_e;

  localparam int unsigned TIMER_WIDTH_DEFAULT = 32'd24;

  // A period is legal when 1 <= period <= 2^width. The upper bound is legal
  // because the terminal compare uses period-1, which still fits in width bits.
  function automatic bit period_ok(input longint unsigned period,
                                   input int unsigned     width);
    return (period >= 64'd1) && (period <= (64'd1 << width));
  endfunction

endpackage

// File: rtl/interval_timer_ch.sv
// -----------------------------------------------------------------------------
// interval_timer_ch
// One-shot interval timer channel. While start_in is held high the channel
// counts PERIOD cycles, then emits a single-cycle int_out pulse and parks in
// DONE until start_in drops, so a held start fires only once.
//
// Ports:
//   clock_in    system clock
//   reset_n_in  asynchronous active-low reset
//   start_in    level request
//   int_out     one-cycle expiry pulse (registered)
//   busy_out    high while the channel is counting (registered)
// -----------------------------------------------------------------------------
module interval_timer_ch
  import timer_pkg::*;
#(
  parameter int unsigned     WIDTH  = TIMER_WIDTH_DEFAULT,
  parameter longint unsigned PERIOD = 64'd1
) (
  input  logic clock_in,
  input  logic reset_n_in,
  input  logic start_in,
  output logic int_out,
  output logic busy_out
);

  // PERIOD = 2^WIDTH truncates the terminal value to all-ones, which is exactly
  // the last count reachable without wrapping.
  localparam logic [WIDTH-1:0] TERM_COUNT = WIDTH'(PERIOD - 64'd1);
  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1'b1);

  timer_state_e     state_r;
  timer_state_e     next_state_s;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] next_count_s;
  logic             int_r;
  logic             busy_r;

  // Next-state and next-count logic; start_in low in RUN aborts even on the
  // terminal count, so an abort always beats the interrupt.
  always_comb begin
    next_state_s = state_r;
    next_count_s = count_r;
    case (state_r)
      ST_IDLE: begin
        next_count_s = '0;
        if (start_in) begin
          next_state_s = ST_RUN;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!start_in) begin
          next_state_s = ST_IDLE;
          next_count_s = '0;
        end else if (count_r == TERM_COUNT) begin
          next_state_s = ST_FIRE;
          next_count_s = '0;
        end else begin
          next_state_s = ST_RUN;
          next_count_s = count_r + COUNT_ONE;
        end
      end
      ST_FIRE: begin
        next_count_s = '0;
        if (start_in) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DONE: begin
        next_count_s = '0;
        if (start_in) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        next_count_s = '0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_r <= ST_IDLE;
      count_r <= '0;
    end else begin
      state_r <= next_state_s;
      count_r <= next_count_s;
    end
  end

  // Outputs are registered copies of the decode of the next state, so they
  // track state_r cycle-for-cycle with no combinational path from start_in.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      int_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      int_r  <= (next_state_s == ST_FIRE);
      busy_r <= (next_state_s == ST_RUN);
    end
  end

  assign int_out  = int_r;
  assign busy_out = busy_r;

endmodule

// File: rtl/interval_timer_bank.sv
// -----------------------------------------------------------------------------
// interval_timer_bank
// Three independent one-shot interval timers answering the start/interrupt
// handshake of the LED sequencing controller (OFF, ON and IDLE intervals).
//
// Ports:
//   clock_in      system clock
//   reset_n_in    asynchronous active-low reset
//   tN_start_in   level request for channel N
//   tN_int_out    one-cycle expiry pulse for channel N
//   busy_out[N]   channel N is counting
// -----------------------------------------------------------------------------
module interval_timer_bank
  import timer_pkg::*;
#(
  parameter int unsigned     WIDTH     = TIMER_WIDTH_DEFAULT,
  parameter longint unsigned T0_PERIOD = 64'd6000000,
  parameter longint unsigned T1_PERIOD = 64'd6000000,
  parameter longint unsigned T2_PERIOD = 64'd12000000
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       t0_start_in,
  input  logic       t1_start_in,
  input  logic       t2_start_in,
  output logic       t0_int_out,
  output logic       t1_int_out,
  output logic       t2_int_out,
  output logic [2:0] busy_out
);

  // Reject periods that cannot be timed by a WIDTH-bit counter.
  if (!period_ok(T0_PERIOD, WIDTH)) begin : g_t0_period_err
    $error("interval_timer_bank: T0_PERIOD out of range 1..2^WIDTH");
  end
  if (!period_ok(T1_PERIOD, WIDTH)) begin : g_t1_period_err
    $error("interval_timer_bank: T1_PERIOD out of range 1..2^WIDTH");
  end
  if (!period_ok(T2_PERIOD, WIDTH)) begin : g_t2_period_err
    $error("interval_timer_bank: T2_PERIOD out of range 1..2^WIDTH");
  end

  logic t0_busy_s;
  logic t1_busy_s;
  logic t2_busy_s;

  interval_timer_ch #(.WIDTH(WIDTH), .PERIOD(T0_PERIOD)) u_ch0 (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .start_in   (t0_start_in),
    .int_out    (t0_int_out),
    .busy_out   (t0_busy_s)
  );

  interval_timer_ch #(.WIDTH(WIDTH), .PERIOD(T1_PERIOD)) u_ch1 (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .start_in   (t1_start_in),
    .int_out    (t1_int_out),
    .busy_out   (t1_busy_s)
  );

  interval_timer_ch #(.WIDTH(WIDTH), .PERIOD(T2_PERIOD)) u_ch2 (
    .clock_in   (clock_in),
    .reset_n_in (reset_n_in),
    .start_in   (t2_start_in),
    .int_out    (t2_int_out),
    .busy_out   (t2_busy_s)
  );

  assign busy_out = {t2_busy_s, t1_busy_s, t0_busy_s};

endmodule

// File: tb/tb_interval_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_interval_timer_bank
// Two bank instances: A (WIDTH=8, periods 5/10/3) and B (WIDTH=4, periods
// 1/16/2). Stimulus pushes the edge number at which each interrupt pulse is
// expected (start sampling edge + PERIOD); a monitor on the falling edge pops
// and compares whenever any int output is high. Leftover entries at the end
// are missed pulses.
// -----------------------------------------------------------------------------
module tb_interval_timer_bank;

  typedef struct {
    int          dut;
    int          ch;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  st_a;
  logic [2:0]  st_b;
  logic [2:0]  int_a;
  logic [2:0]  int_b;
  logic [2:0]  busy_a;
  logic [2:0]  busy_b;

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];

  always #5 clk = ~clk;

  // Edge counter: after posedge number n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  interval_timer_bank #(.WIDTH(8), .T0_PERIOD(5), .T1_PERIOD(10), .T2_PERIOD(3)) dut_a (
    .clock_in    (clk),
    .reset_n_in  (rst_n),
    .t0_start_in (st_a[0]),
    .t1_start_in (st_a[1]),
    .t2_start_in (st_a[2]),
    .t0_int_out  (int_a[0]),
    .t1_int_out  (int_a[1]),
    .t2_int_out  (int_a[2]),
    .busy_out    (busy_a)
  );

  interval_timer_bank #(.WIDTH(4), .T0_PERIOD(1), .T1_PERIOD(16), .T2_PERIOD(2)) dut_b (
    .clock_in    (clk),
    .reset_n_in  (rst_n),
    .t0_start_in (st_b[0]),
    .t1_start_in (st_b[1]),
    .t2_start_in (st_b[2]),
    .t0_int_out  (int_b[0]),
    .t1_int_out  (int_b[1]),
    .t2_int_out  (int_b[2]),
    .busy_out    (busy_b)
  );

  // Scoreboard monitor: every observed pulse must match the oldest pending
  // expectation for that instance/channel, at the expected edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 3; c++) begin
        logic hit;
        int   idx;
        hit = (d == 0) ? int_a[c] : int_b[c];
        if (hit) begin
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].dut == d && exp_q[i].ch == c) idx = i;
          end
          n_cmp++;
          if (idx < 0) begin
            n_bad++;
            $display("FAIL pulse dut%0d ch%0d: got pulse at edge %0d, required none", d, c, cyc);
          end else begin
            if (exp_q[idx].cyc != cyc) begin
              n_bad++;
              $display("FAIL pulse dut%0d ch%0d: got edge %0d, required edge %0d",
                       d, c, cyc, exp_q[idx].cyc);
            end
            exp_q.delete(idx);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a falling edge, immediately after raising start: the
  // next rising edge samples it, so the pulse lands at (cyc + 1) + period.
  task automatic expect_pulse(input int d, input int c, input int unsigned period);
    exp_t e;
    e.dut = d;
    e.ch  = c;
    e.cyc = cyc + 1 + period;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st_a  = 3'b000;
    st_b  = 3'b000;
    tick(3);
    chk("reset busy_a", int'(busy_a), 0);
    chk("reset busy_b", int'(busy_b), 0);
    chk("reset int_a",  int'(int_a),  0);
    chk("reset int_b",  int'(int_b),  0);
    rst_n = 1'b1;
    tick(2);

    // ch1 period 10 held: busy through edge k+9, pulse at k+10, then DONE.
    st_a[1] = 1'b1; expect_pulse(0, 1, 10);
    tick(1);  chk("p10 busy at k",   int'(busy_a[1]), 1);
    tick(9);  chk("p10 busy at k+9", int'(busy_a[1]), 1);
    tick(1);  chk("p10 busy at fire", int'(busy_a[1]), 0);
    tick(10); chk("p10 busy in done", int'(busy_a[1]), 0);
    st_a[1] = 1'b0;
    tick(2);

    // ch0 period 5: drop after the pulse, re-raise 2 cycles later.
    st_a[0] = 1'b1; expect_pulse(0, 0, 5);
    tick(7);  st_a[0] = 1'b0;
    tick(2);  st_a[0] = 1'b1; expect_pulse(0, 0, 5);
    tick(6);  st_a[0] = 1'b0;
    tick(2);

    // ch2 period 3: early abort, abort on the terminal count, then full hold.
    st_a[2] = 1'b1;
    tick(2);  st_a[2] = 1'b0;
    tick(1);  chk("p3 abort busy", int'(busy_a[2]), 0);
    tick(1);
    st_a[2] = 1'b1;
    tick(3);  chk("p3 busy at terminal", int'(busy_a[2]), 1);
    st_a[2] = 1'b0;
    tick(1);  chk("p3 terminal abort busy", int'(busy_a[2]), 0);
    tick(3);
    st_a[2] = 1'b1; expect_pulse(0, 2, 3);
    tick(5);  st_a[2] = 1'b0;
    tick(2);

    // ch0 start dropped during FIRE: pulse completes, IDLE, then re-arm.
    st_a[0] = 1'b1; expect_pulse(0, 0, 5);
    tick(6);  st_a[0] = 1'b0;
    tick(1);  chk("drop in fire busy", int'(busy_a[0]), 0);
    st_a[0] = 1'b1; expect_pulse(0, 0, 5);
    tick(7);  st_a[0] = 1'b0;
    tick(2);

    // Instance B: period 1 and period 2^WIDTH.
    st_b[0] = 1'b1; expect_pulse(1, 0, 1);
    tick(1);  chk("p1 busy at k", int'(busy_b[0]), 1);
    tick(1);  chk("p1 busy at fire", int'(busy_b[0]), 0);
    st_b[0] = 1'b0;
    tick(2);
    st_b[1] = 1'b1; expect_pulse(1, 1, 16);
    tick(16); chk("p16 busy at k+15", int'(busy_b[1]), 1);
    tick(20); chk("p16 busy in done", int'(busy_b[1]), 0);
    st_b[1] = 1'b0;
    tick(2);

    // All three channels of A together: pulses at +3, +5, +10.
    st_a = 3'b111;
    expect_pulse(0, 0, 5); expect_pulse(0, 1, 10); expect_pulse(0, 2, 3);
    tick(1);  chk("all busy at k", int'(busy_a), 7);
    tick(4);  chk("all busy at k+4", int'(busy_a), 3);
    tick(7);  chk("all busy at end", int'(busy_a), 0);
    st_a = 3'b000;
    tick(2);

    // Asynchronous reset mid-run of ch1: busy clears at once, no pulse later.
    st_a[1] = 1'b1;
    tick(4);  chk("pre-reset busy", int'(busy_a[1]), 1);
    #2 rst_n = 1'b0;
    #1 chk("async reset busy", int'(busy_a), 0);
    chk("async reset int", int'(int_a), 0);
    st_a[1] = 1'b0;
    tick(2);  rst_n = 1'b1;
    tick(12); chk("post-reset busy", int'(busy_a), 0);
    st_a[1] = 1'b1; expect_pulse(0, 1, 10);
    tick(11); st_a[1] = 1'b0;
    tick(3);

    while (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing pulse dut%0d ch%0d: got none, required edge %0d",
               exp_q[0].dut, exp_q[0].ch, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
